// File: rtl/mio_bridge.sv
// mio_bridge: memory-mapped I/O bridge between the multicycle CPU controller
// and a wait-stated RAM, a GPIO register and a free-running 32-bit counter.
// Region by addr[31:28]: 0x0 RAM, 0xE GPIO, 0xF counter, anything else is a bus error.
module mio_bridge #(
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned RAM_AW  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mio,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_w,
    output logic [31:0]       data_r,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [31:0]       gpio_in,
    output logic [31:0]       gpio_out,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} state_t;
    typedef enum logic [1:0] {K_RAM, K_GPIO, K_CNT, K_ERR} kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [RAM_AW-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [3:0]        wait_q, wait_d;
    logic [31:0]       data_r_q, data_r_d;
    logic [31:0]       gpio_q, gpio_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              req;
    kind_t             kind_in;

    // The region is decoded at acceptance and latched as a kind, so only the
    // RAM word index of the address needs to be held afterwards.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[1:0], addr[27:RAM_AW+2]};

    assign req = cpu_mio & (mem_r | mem_w);

    // Region decode of the incoming request; a simultaneous read and write is always an error.
    always_comb begin
        kind_in = K_ERR;
        if (!(mem_r && mem_w)) begin
            case (addr[31:28])
                4'h0:    kind_in = K_RAM;
                4'hE:    kind_in = K_GPIO;
                4'hF:    kind_in = K_CNT;
                default: kind_in = K_ERR;
            endcase
        end
    end

    // State register and all architectural registers, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            kind_q   <= K_RAM;
            idx_q    <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wait_q   <= '0;
            data_r_q <= '0;
            gpio_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wait_q   <= wait_d;
            data_r_q <= data_r_d;
            gpio_q   <= gpio_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: acceptance, RAM wait counting and register updates on entry to DONE.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        wait_d   = wait_q;
        data_r_d = data_r_q;
        gpio_d   = gpio_q;
        cnt_d    = cnt_q + 32'd1;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    kind_d  = kind_in;
                    idx_d   = addr[RAM_AW+1:2];
                    wdata_d = data_w;
                    rd_d    = mem_r;
                    wr_d    = mem_w;
                    if (kind_in == K_RAM) begin
                        state_d = RAM_WAIT;
                        wait_d  = 4'd1;
                    end else begin
                        // Single-cycle targets complete on the edge entering DONE,
                        // so they act on the live inputs rather than the latched copy.
                        state_d  = DONE;
                        data_r_d = '0;
                        case (kind_in)
                            K_GPIO: begin
                                if (mem_w) gpio_d = data_w;
                                if (mem_r) data_r_d = gpio_in;
                            end
                            K_CNT: begin
                                if (mem_w) cnt_d = data_w;
                                if (mem_r) data_r_d = cnt_q;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end
            RAM_WAIT: begin
                if (wait_q == 4'(RAM_LAT)) begin
                    state_d  = DONE;
                    data_r_d = rd_q ? ram_dout : '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mio_ready = (state_q == DONE);
    assign ram_we    = (state_q == DONE) && (kind_q == K_RAM) && wr_q;
    assign ram_addr  = idx_q;
    assign ram_din   = wdata_q;
    assign data_r    = data_r_q;
    assign gpio_out  = gpio_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mio_bridge.sv
// tb_mio_bridge: table-driven transactions checked by a scoreboard against
// mio_bridge, plus hand-written sequences for counter wrap, held requests and
// reset during a RAM access.
module tb_mio_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mio, mem_r, mem_w;
    logic [31:0] addr, data_w, data_r, ram_din, ram_dout, gpio_in, gpio_out;
    logic        mio_ready, ram_we, bus_err;
    logic [9:0]  ram_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic err_model = 1'b0;

    logic [31:0] ram_mem [1024];

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] gin;
        logic [31:0] exp_data;
        logic [31:0] exp_gpio;
        int          lat;
        logic        we;
        logic [9:0]  ra;
        logic        is_err;
    } vec_t;

    typedef struct {
        int          start;
        int          lat;
        logic [31:0] data;
        logic [31:0] gpio;
        logic [31:0] din;
        logic        we;
        logic        err;
        logic [9:0]  ra;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[14];

    mio_bridge #(.RAM_LAT(2), .RAM_AW(10)) dut (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio), .mem_r(mem_r), .mem_w(mem_w),
        .addr(addr), .data_w(data_w), .data_r(data_r), .mio_ready(mio_ready),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM behind the bridge.
    assign ram_dout = ram_mem[ram_addr];
    always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_din;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every completion pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ram_we) chk32("ram_we_only_in_done", {31'd0, mio_ready}, 32'd1);
        if (mio_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mio_ready: got 1 expected 0 (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk32("latency", 32'(cyc - e.start), 32'(e.lat));
                chk32("data_r", data_r, e.data);
                chk32("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                chk32("ram_we", {31'd0, ram_we}, {31'd0, e.we});
                chk32("gpio_out", gpio_out, e.gpio);
                if (e.we) begin
                    chk32("ram_addr", {22'd0, ram_addr}, {22'd0, e.ra});
                    chk32("ram_din", ram_din, e.din);
                end
            end
        end
    end

    task automatic push_exp(input vec_t v, input int lat);
        exp_t e;
        e.start = cyc;
        e.lat   = lat;
        e.data  = v.exp_data;
        e.gpio  = v.exp_gpio;
        e.din   = v.wdata;
        e.we    = v.we;
        e.err   = err_model;
        e.ra    = v.ra;
        sbq.push_back(e);
    endtask

    // One complete transaction; inputs are scrambled after acceptance and must be ignored.
    task automatic txn(input vec_t v);
        bit done;
        @(posedge clk); #1;
        cpu_mio = 1'b1; mem_r = v.r; mem_w = v.w;
        addr = v.addr; data_w = v.wdata; gpio_in = v.gin;
        err_model = err_model | v.is_err;
        push_exp(v, v.lat);
        @(posedge clk); #1;
        addr   = ~v.addr;
        data_w = ~v.wdata;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (mio_ready) done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
        chk32("txn_completes", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk32({tag, "_data_r"}, data_r, '0);
        chk32({tag, "_mio_ready"}, {31'd0, mio_ready}, '0);
        chk32({tag, "_ram_we"}, {31'd0, ram_we}, '0);
        chk32({tag, "_gpio_out"}, gpio_out, '0);
        chk32({tag, "_bus_err"}, {31'd0, bus_err}, '0);
        chk32({tag, "_ram_addr"}, {22'd0, ram_addr}, '0);
        chk32({tag, "_ram_din"}, ram_din, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 1024; i++) ram_mem[i] = '0;

        //         r     w     addr          wdata         gin           exp_data      exp_gpio  lat we    ra       err
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        32'h0,        32'h0,        3, 1'b1, 10'h004, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0,        32'hDEAD_BEEF, 32'h0,       3, 1'b0, 10'h000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h1122_3344, 32'h0,        32'h0,        32'h0,        3, 1'b1, 10'h3FF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'h0,        32'h1122_3344, 32'h0,       3, 1'b0, 10'h000, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_1010, 32'hCAFE_F00D, 32'h0,        32'h0,        32'h0,        3, 1'b1, 10'h004, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0,        32'hCAFE_F00D, 32'h0,       3, 1'b0, 10'h000, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'hE000_0000, 32'h5A5A_0001, 32'h0,        32'h0,        32'h5A5A_0001, 1, 1'b0, 10'h000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'hE000_0000, 32'h0,         32'h1234_5678, 32'h1234_5678, 32'h5A5A_0001, 1, 1'b0, 10'h000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'hE000_1234, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h5A5A_0001, 1, 1'b0, 10'h000, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0101_0101, 32'h0,        32'h0,        32'h5A5A_0001, 1, 1'b0, 10'h000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h0,        32'h0,        32'h5A5A_0001, 1, 1'b0, 10'h000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h3000_0000, 32'h7777_7777, 32'h0,        32'h0,        32'h5A5A_0001, 1, 1'b0, 10'h000, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'hE000_0000, 32'hFFFF_FFFF, 32'h0,        32'h0,        32'h5A5A_0001, 1, 1'b0, 10'h000, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0,        32'hCAFE_F00D, 32'h5A5A_0001, 3, 1'b0, 10'h000, 1'b0};

        reset = 1'b1; cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
        addr = '0; data_w = '0; gpio_in = '0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Request qualifier low: a would-be GPIO write must do nothing.
        @(posedge clk); #1;
        mem_w = 1'b1; addr = 32'hE000_0000; data_w = 32'hFFFF_0000;
        repeat (4) @(posedge clk);
        #1;
        chk32("no_mio_gpio_out", gpio_out, '0);
        chk32("no_mio_bus_err", {31'd0, bus_err}, '0);
        mem_w = 1'b0;

        for (int i = 0; i < 14; i++) txn(vecs[i]);

        // Counter: load 0xFFFFFFFE, read two cycles after the load edge -> wrapped 0, then 2.
        v = '{1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h5A5A_0001, 1, 1'b0, 10'h0, 1'b0};
        txn(v);
        @(posedge clk);
        v = '{1'b1, 1'b0, 32'hF000_0000, 32'h0, 32'h0, 32'h0000_0000, 32'h5A5A_0001, 1, 1'b0, 10'h0, 1'b0};
        txn(v);
        v = '{1'b1, 1'b0, 32'hF000_0000, 32'h0, 32'h0, 32'h0000_0002, 32'h5A5A_0001, 1, 1'b0, 10'h0, 1'b0};
        txn(v);

        // Held RAM read: completions at cycle 3 and cycle 3 + RAM_LAT + 2.
        @(posedge clk); #1;
        cpu_mio = 1'b1; mem_r = 1'b1; mem_w = 1'b0; addr = 32'h0000_0010;
        v = '{1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h5A5A_0001, 3, 1'b0, 10'h0, 1'b0};
        push_exp(v, 3);
        push_exp(v, 7);
        repeat (7) @(posedge clk);
        #1 chk32("held_second_done", {31'd0, mio_ready}, 32'd1);
        cpu_mio = 1'b0; mem_r = 1'b0;
        repeat (4) @(posedge clk);

        // Reset during RAM_WAIT of a write: aborted, no write, outputs cleared.
        @(posedge clk); #1;
        cpu_mio = 1'b1; mem_w = 1'b1; addr = 32'h0000_0020; data_w = 32'h0000_0099;
        @(posedge clk); #2;
        reset = 1'b1;
        #1 chk_all_zero("reset_mid");
        cpu_mio = 1'b0; mem_w = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        err_model = 1'b0;

        v = '{1'b1, 1'b0, 32'hE000_0000, 32'h0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0, 1, 1'b0, 10'h0, 1'b0};
        txn(v);
        v = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 32'h0, 32'h0, 3, 1'b0, 10'h0, 1'b0};
        txn(v);

        repeat (3) @(posedge clk);
        #1 chk32("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
